// File: rtl/level_ctl_pkg.sv
// Shared game definitions: FSM state encoding, level codes and default timing.
// Also used by the obstacle drawer and the collision logic.
package level_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_LANDED  = 3'd2,
    ST_CRASHED = 3'd3,
    ST_WIN     = 3'd4,
    ST_OVER    = 3'd5
  } game_state_e;

  // Level codes: 0 draws no obstacles, 1..LVL_MAX are playable levels.
  localparam logic [2:0] LVL_NONE  = 3'd0;
  localparam logic [2:0] LVL_FIRST = 3'd1;
  localparam int         LVL_MAX   = 3;

  localparam int WAIT_FRAMES_DEF = 120;
  localparam int LIVES_INIT_DEF  = 3;

  // Lives count that never underflows below zero.
  function automatic logic [1:0] lives_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/level_ctl_frame_tick.sv
// Frame tick generator: one-cycle pulse on each rising edge of vsync.
// Shared by every block that advances at frame rate.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;

  // Delay vsync by one clock so its rising edge can be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      vsync_q <= vsync_i;
    end
  end

  assign tick_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/level_ctl.sv
// Lunar-lander game sequencer: level progression, lives, pause timing and
// the start/win/game-over flow. Everything advances only on frame ticks.
module level_ctl
  import level_ctl_pkg::*;
#(
  parameter int WAIT_FRAMES = WAIT_FRAMES_DEF,
  parameter int NUM_LVL     = LVL_MAX,
  parameter int LIVES_INIT  = LIVES_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       landed,
  input  logic       crashed,
  output logic [2:0] lvl,
  output logic [1:0] lives,
  output logic       load_pos,
  output logic       freeze,
  output logic       game_over,
  output logic       win
);

  localparam int             CW        = $clog2(WAIT_FRAMES + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(WAIT_FRAMES - 1);
  localparam logic [2:0]     LVL_TOP   = 3'(NUM_LVL);
  localparam logic [1:0]     LIVES_RST = 2'(LIVES_INIT);

  logic tick;
  logic start_q;
  logic start_rise;

  game_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          pend_start_q, pend_land_q, pend_crash_q;
  logic [2:0]    lvl_q;
  logic [1:0]    lives_q;
  logic          load_pos_q, freeze_q, game_over_q, win_q;

  // Events seen so far this frame, including one arriving on the tick itself.
  logic start_ev, land_ev, crash_ev;

  frame_tick u_frame_tick (
    .clk     (clk),
    .rst     (rst),
    .vsync_i (vsync_in),
    .tick_o  (tick)
  );

  // Start button edge detector; holding the button never retriggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start_btn;
  end

  assign start_rise = start_btn & ~start_q;
  assign start_ev   = pend_start_q | start_rise;
  assign land_ev    = pend_land_q  | landed;
  assign crash_ev   = pend_crash_q | crashed;

  // Sequencer: latch events between ticks, change state and outputs on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_start_q <= 1'b0;
      pend_land_q  <= 1'b0;
      pend_crash_q <= 1'b0;
      lvl_q        <= LVL_NONE;
      lives_q      <= LIVES_RST;
      load_pos_q   <= 1'b0;
      freeze_q     <= 1'b1;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      // NOTE: load_pos defaults low every cycle and is raised only on PLAY entry, so it is a single-cycle pulse.
      load_pos_q <= 1'b0;
      if (tick) begin
        pend_start_q <= 1'b0;
        pend_land_q  <= 1'b0;
        pend_crash_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (start_ev) begin
              state_q    <= ST_PLAY;
              lvl_q      <= LVL_FIRST;
              load_pos_q <= 1'b1;
              freeze_q   <= 1'b0;
            end
          end
          ST_PLAY: begin
            if (crash_ev) begin
              state_q  <= ST_CRASHED;
              lives_q  <= lives_dec(lives_q);
              cnt_q    <= '0;
              freeze_q <= 1'b1;
            end else if (land_ev) begin
              state_q  <= ST_LANDED;
              cnt_q    <= '0;
              freeze_q <= 1'b1;
            end
          end
          ST_LANDED: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (lvl_q < LVL_TOP) begin
                state_q    <= ST_PLAY;
                lvl_q      <= lvl_q + 3'd1;
                load_pos_q <= 1'b1;
                freeze_q   <= 1'b0;
              end else begin
                state_q <= ST_WIN;
                win_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_CRASHED: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (lives_q != 2'd0) begin
                state_q    <= ST_PLAY;
                load_pos_q <= 1'b1;
                freeze_q   <= 1'b0;
              end else begin
                state_q     <= ST_OVER;
                game_over_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_WIN, ST_OVER: begin
            if (start_ev) begin
              state_q     <= ST_IDLE;
              lvl_q       <= LVL_NONE;
              lives_q     <= LIVES_RST;
              game_over_q <= 1'b0;
              win_q       <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else begin
        if (start_rise && (state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_OVER))
          pend_start_q <= 1'b1;
        if (landed && state_q == ST_PLAY)
          pend_land_q <= 1'b1;
        if (crashed && state_q == ST_PLAY)
          pend_crash_q <= 1'b1;
      end
    end
  end

  assign lvl       = lvl_q;
  assign lives     = lives_q;
  assign load_pos  = load_pos_q;
  assign freeze    = freeze_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: doc/level_ctl.md
LEVEL_CTL -- requirements
Module: level_ctl

Interface
REQ-001 Parameter WAIT_FRAMES, default 120; frames held in the LANDED/CRASHED pause states.
REQ-002 Parameter NUM_LVL, default 3; highest playable level code.
REQ-003 Parameter LIVES_INIT, default 3; lives at game start.
REQ-004 clk  in  1  single pixel clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 vsync_in  in  1  VGA vsync from the timing chain; its rising edge is the frame tick.
REQ-007 start_btn  in  1  synchronized, debounced start button, level-sensitive.
REQ-008 landed  in  1  lander on pad within speed limits, from collision logic.
REQ-009 crashed  in  1  lander touched an obstacle or hit the pad too fast.
REQ-010 lvl  out  3  level code to the obstacle drawer; 0 means no obstacles.
REQ-011 lives  out  2  remaining lives.
REQ-012 load_pos  out  1  one-cycle pulse that reloads the lander start position and velocity.
REQ-013 freeze  out  1  high = lander physics halted.
REQ-014 game_over  out  1  high in state OVER.
REQ-015 win  out  1  high in state WIN.

Function
REQ-016 Frame tick: the rising edge of vsync_in, detected with one register stage, yields a one-cycle pulse `tick`.
REQ-017 FSM states: IDLE, PLAY, LANDED, CRASHED, WIN, OVER. All outputs are registered.
REQ-018 IDLE: lvl=0, freeze=1, lives=LIVES_INIT.
- A rising edge of start_btn moves to PLAY at the next tick, with lvl=1 and a load_pos pulse.
REQ-019 lvl, lives and state change only in the cycle of a tick; events between ticks are latched in pending flags and consumed at the next tick.
REQ-020 PLAY: freeze=0.
- A latched crashed moves to CRASHED.
- Otherwise a latched landed moves to LANDED.
- If both are latched in the same frame, crashed has priority.
REQ-021 LANDED and CRASHED: freeze=1; the frame counter counts ticks from 0 up to WAIT_FRAMES-1.
REQ-022 LANDED exit, on the tick that completes the wait:
- lvl<NUM_LVL: lvl increments and the FSM goes to PLAY with a load_pos pulse.
- lvl==NUM_LVL: the FSM goes to WIN.
REQ-023 CRASHED on entry: lives decrements, saturating at 0.
REQ-024 CRASHED exit, on the tick that completes the wait:
- lives>0: the FSM goes to PLAY at the same lvl with a load_pos pulse.
- lives==0: the FSM goes to OVER.
REQ-025 WIN and OVER: freeze=1, lvl holds its value.
- A rising edge of start_btn returns the FSM to IDLE on the next tick.
REQ-026 landed, crashed and start_btn are ignored outside the states listed above; pending flags clear on every state change.
REQ-027 load_pos is exactly one clk cycle wide and is asserted only on entry to PLAY.
REQ-028 lvl never takes a value above NUM_LVL; the frame counter is wide enough for WAIT_FRAMES and never wraps inside a wait.
REQ-029 start_btn held high across a state change does not retrigger; only a new rising edge counts.

Reset
REQ-030 rst asynchronously forces:
- state=IDLE, lvl=0, lives=LIVES_INIT, load_pos=0, freeze=1, game_over=0, win=0;
- counter, pending flags and edge-detect registers to 0.
REQ-031 Asserting rst mid-PLAY or mid-wait aborts immediately; no load_pos pulse follows release.

Structure
REQ-032 State encoding, the level codes (0 = none, 1..3) and the WAIT_FRAMES/LIVES_INIT defaults live in a shared game package, also used by the obstacle drawer and collision logic.
REQ-033 The vsync edge detector is a sub-module, frame_tick, reused by the other frame-rate blocks.

Verification
REQ-034 rst pulse, then start_btn edge -> first tick after it: lvl=1, one load_pos pulse, freeze=0.
REQ-035 PLAY lvl=1, landed asserted -> LANDED; 120 ticks later lvl=2 with load_pos; repeated at lvl=3 -> win=1, lvl stays 3.
REQ-036 landed and crashed asserted in the same frame -> CRASHED, lives 3->2, lvl unchanged.
REQ-037 Three crashes -> lives=0, game_over=1 after the third wait; start_btn edge -> IDLE, lvl=0, lives=3.
REQ-038 rst asserted 50 ticks into LANDED -> outputs at reset values within the same cycle; no load_pos pulse.
REQ-039 start_btn held high from IDLE through PLAY to OVER -> no return to IDLE until it is released and pressed again.
